// File: rtl/wb_mtimer.sv
`default_nettype none
// ============================================================================
// Module   : wb_mtimer
// Purpose  : Wishbone B4 pipelined slave holding the RISC-V machine timer
//            (64-bit mtime / mtimecmp) with a programmable prescaler and a
//            registered level timer interrupt.
// Options  : `define WB_MTIMER_HI_LATCH_EN to make a MTIME_LO read capture
//            mtime[63:32] into a shadow that MTIME_HI reads return.
// Revision : 1.0 - initial release
// ============================================================================
module wb_mtimer #(
  parameter int          ADDR_W       = 5,
  parameter int          DIV_W        = 16,   // must not exceed 24 (CTRL[31:8])
  parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_stall_o,
  output logic              irq_timer_o
);

  // Word indices inside the 32-byte register window
  localparam logic [ADDR_W-3:0] MTIME_LO_A    = (ADDR_W-2)'(0);
  localparam logic [ADDR_W-3:0] MTIME_HI_A    = (ADDR_W-2)'(1);
  localparam logic [ADDR_W-3:0] MTIMECMP_LO_A = (ADDR_W-2)'(2);
  localparam logic [ADDR_W-3:0] MTIMECMP_HI_A = (ADDR_W-2)'(3);
  localparam logic [ADDR_W-3:0] CTRL_A        = (ADDR_W-2)'(4);

  // Architectural state
  logic [63:0]      mtime, mtime_nxt;
  logic [63:0]      mtimecmp, mtimecmp_nxt;
  logic             en, en_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic [DIV_W-1:0] pcount, pcount_nxt;
  logic             ack_pend, ack_pend_nxt;
  logic [31:0]      rdata, rdata_nxt;
  logic             irq, irq_nxt;
`ifdef WB_MTIMER_HI_LATCH_EN
  logic [31:0]      shadow, shadow_nxt;
`endif

  // Decode helpers
  logic              req, wr, rd;
  logic [ADDR_W-3:0] word;
  logic              tick;
  logic [63:0]       mtime_inc;
  logic [31:0]       ctrl_word, ctrl_merged;
  logic [31:0]       mtime_hi_rd;
  logic [31:0]       rd_mux;
  logic              unused_ok;

  // Replace the bytes of old_v whose lane enable is set with the bus data
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  assign req       = wb_cyc_i & wb_stb_i;
  assign wr        = req & wb_we_i;
  assign rd        = req & ~wb_we_i;
  assign word      = wb_adr_i[ADDR_W-1:2];
  assign tick      = en && (pcount == div);
  assign mtime_inc = mtime + 64'd1;
  assign unused_ok = &{1'b0, wb_adr_i[1:0], ctrl_merged[7:1], ctrl_merged[31:8+DIV_W]};

`ifdef WB_MTIMER_HI_LATCH_EN
  assign mtime_hi_rd = shadow;
`else
  assign mtime_hi_rd = mtime[63:32];
`endif

  // CTRL register image as seen by the bus, and its lane-merged write value
  always_comb begin
    ctrl_word             = '0;
    ctrl_word[0]          = en;
    ctrl_word[8 +: DIV_W] = div;
  end

  assign ctrl_merged = merge_lanes(ctrl_word, wb_dat_i, wb_sel_i);

  // Read mux: values as they stand before the acceptance edge
  always_comb begin
    rd_mux = '0;
    case (word)
      MTIME_LO_A:    rd_mux = mtime[31:0];
      MTIME_HI_A:    rd_mux = mtime_hi_rd;
      MTIMECMP_LO_A: rd_mux = mtimecmp[31:0];
      MTIMECMP_HI_A: rd_mux = mtimecmp[63:32];
      CTRL_A:        rd_mux = ctrl_word;
      default:       rd_mux = '0;
    endcase
  end

  // Next-state: counting, bus writes (which win over the increment), response
  always_comb begin
    mtime_nxt    = tick ? mtime_inc : mtime;
    mtimecmp_nxt = mtimecmp;
    en_nxt       = en;
    div_nxt      = div;
    ack_pend_nxt = req;
    rdata_nxt    = rd ? rd_mux : 32'h0;

    if (tick) begin
      pcount_nxt = '0;
    end else if (en) begin
      pcount_nxt = pcount + DIV_W'(1);
    end else begin
      pcount_nxt = pcount;
    end

`ifdef WB_MTIMER_HI_LATCH_EN
    shadow_nxt = shadow;
    if (rd && (word == MTIME_LO_A)) begin
      shadow_nxt = mtime[63:32];
    end
`endif

    if (wr) begin
      case (word)
        // A half-write suppresses the whole increment: no carry into the other half
        MTIME_LO_A: mtime_nxt = {mtime[63:32], merge_lanes(mtime[31:0], wb_dat_i, wb_sel_i)};
        MTIME_HI_A: begin
          mtime_nxt = {merge_lanes(mtime[63:32], wb_dat_i, wb_sel_i), mtime[31:0]};
`ifdef WB_MTIMER_HI_LATCH_EN
          shadow_nxt = merge_lanes(mtime[63:32], wb_dat_i, wb_sel_i);
`endif
        end
        MTIMECMP_LO_A: mtimecmp_nxt[31:0]  = merge_lanes(mtimecmp[31:0], wb_dat_i, wb_sel_i);
        MTIMECMP_HI_A: mtimecmp_nxt[63:32] = merge_lanes(mtimecmp[63:32], wb_dat_i, wb_sel_i);
        CTRL_A: begin
          en_nxt     = ctrl_merged[0];
          div_nxt    = ctrl_merged[8 +: DIV_W];
          pcount_nxt = '0;
        end
        default: ;
      endcase
    end

    irq_nxt = (mtime_nxt >= mtimecmp_nxt);
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mtime    <= '0;
      mtimecmp <= MTIMECMP_RST;
      en       <= 1'b1;
      div      <= '0;
      pcount   <= '0;
      ack_pend <= 1'b0;
      rdata    <= '0;
      irq      <= 1'b0;
`ifdef WB_MTIMER_HI_LATCH_EN
      shadow   <= '0;
`endif
    end else begin
      mtime    <= mtime_nxt;
      mtimecmp <= mtimecmp_nxt;
      en       <= en_nxt;
      div      <= div_nxt;
      pcount   <= pcount_nxt;
      ack_pend <= ack_pend_nxt;
      rdata    <= rdata_nxt;
      irq      <= irq_nxt;
`ifdef WB_MTIMER_HI_LATCH_EN
      shadow   <= shadow_nxt;
`endif
    end
  end

  // An ack is dropped when the master has abandoned the cycle
  assign wb_ack_o    = ack_pend & wb_cyc_i;
  assign wb_dat_o    = wb_ack_o ? rdata : 32'h0;
  assign wb_stall_o  = 1'b0;
  assign irq_timer_o = irq;

endmodule
`default_nettype wire

// File: tb/tb_wb_mtimer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_mtimer
// Purpose  : Self-checking bench for wb_mtimer. The expected timer value is
//            computed arithmetically from the cycle count since the last
//            configuration/mtime change.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_mtimer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [4:0]  adr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_i = '0;
  logic [31:0] dat_o;
  logic        ack, stall, irq;

  int checks   = 0;
  int failures = 0;

  wb_mtimer dut (
    .clk_i(clk), .rst_i(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(dat_i),
    .wb_dat_o(dat_o), .wb_ack_o(ack), .wb_stall_o(stall),
    .irq_timer_o(irq)
  );

  always #5 clk = ~clk;

  // Free-running edge counter; time since reset release is edges - rel0
  longint edges = 0;
  longint rel0  = 0;
  always @(posedge clk) edges <= edges + 1;

  function automatic longint now();
    return edges - rel0;
  endfunction

  // Reference model: state at the last rebase edge m_b, extrapolated by arithmetic
  logic [63:0] m_base, m_cmp;
  longint      m_b, m_p, m_div;
  logic        m_en;
  logic [31:0] m_shadow;

  function automatic logic [63:0] mt(input longint n);
    if (!m_en) return m_base;
    return m_base + 64'((n - m_b + m_p) / (m_div + 1));
  endfunction

  function automatic longint pc(input longint n);
    if (!m_en) return m_p;
    return (n - m_b + m_p) % (m_div + 1);
  endfunction

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  task automatic model_reset();
    m_base = '0; m_b = 0; m_p = 0; m_en = 1'b1; m_div = 0;
    m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_shadow = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Read accepted at edge w returns state as of edge w-1
  task automatic model_read(input int word, input longint w, output logic [31:0] v);
    logic [63:0] t;
    t = mt(w - 1);
    case (word)
      0: begin
        v = t[31:0];
`ifdef WB_MTIMER_HI_LATCH_EN
        m_shadow = t[63:32];
`endif
      end
`ifdef WB_MTIMER_HI_LATCH_EN
      1: v = m_shadow;
`else
      1: v = t[63:32];
`endif
      2: v = m_cmp[31:0];
      3: v = m_cmp[63:32];
      4: v = {8'h00, 16'(m_div), 7'h00, m_en};
      default: v = 32'h0;
    endcase
  endtask

  task automatic model_write(input int word, input logic [3:0] s, input logic [31:0] d,
                             input longint w);
    logic [63:0] t;
    logic [31:0] cw, hi;
    longint      p;
    case (word)
      0: begin
        t = mt(w - 1); p = pc(w);
        m_base = {t[63:32], lanes(t[31:0], d, s)}; m_b = w; m_p = p;
      end
      1: begin
        t = mt(w - 1); p = pc(w);
        hi = lanes(t[63:32], d, s);
        m_base = {hi, t[31:0]}; m_b = w; m_p = p;
`ifdef WB_MTIMER_HI_LATCH_EN
        m_shadow = hi;
`endif
      end
      2: m_cmp[31:0]  = lanes(m_cmp[31:0], d, s);
      3: m_cmp[63:32] = lanes(m_cmp[63:32], d, s);
      4: begin
        t  = mt(w);
        cw = lanes({8'h00, 16'(m_div), 7'h00, m_en}, d, s);
        m_base = t; m_b = w; m_p = 0;
        m_en = cw[0]; m_div = longint'(cw[23:8]);
      end
      default: ;
    endcase
  endtask

  task automatic chk_irq(input string tag);
    chk(tag, {63'h0, irq}, {63'h0, (mt(now()) >= m_cmp)});
  endtask

  // Idle cycles: no ack, interrupt tracks the model every cycle
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      chk("idle_ack", {63'h0, ack}, 64'h0);
      chk_irq("idle_irq");
    end
  endtask

  // One request issued at a negedge; response checked at the following negedge.
  // Consecutive calls therefore present back-to-back requests.
  task automatic bus(input string tag, input logic w_e, input int word, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] rdv);
    longint      w;
    logic [31:0] expv;
    cyc = 1'b1; stb = 1'b1; we = w_e; adr = 5'(word * 4); sel = s; dat_i = d;
    w = now() + 1;
    @(negedge clk);
    expv = 32'h0;
    if (w_e) model_write(word, s, d, w);
    else     model_read(word, w, expv);
    rdv = dat_o;
    chk({tag, "_ack"}, {63'h0, ack}, 64'h1);
    chk({tag, "_stall"}, {63'h0, stall}, 64'h0);
    chk({tag, "_data"}, {32'h0, dat_o}, {32'h0, expv});
    chk_irq({tag, "_irq"});
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    logic [31:0] v, a, b;
    longint      w;
    int          word;
    logic [31:0] d;

    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_ack", {63'h0, ack}, 64'h0);
    chk("rst_dat", {32'h0, dat_o}, 64'h0);
    chk("rst_irq", {63'h0, irq}, 64'h0);
    rst = 1'b0;
    rel0 = edges;
    model_reset();

    // Free-running at DIV=0: ten count edges give 0xA
    idle(10);
    bus("mtime_10", 1'b0, 0, 4'hF, 32'h0, v);
    chk("mtime_10_const", {32'h0, v}, 64'hA);
    bus("ctrl_rst", 1'b0, 4, 4'hF, 32'h0, v);
    bus("cmp_rst_hi", 1'b0, 3, 4'hF, 32'h0, v);

    // Prescale by 4, then freeze
    bus("ctrl_div3", 1'b1, 4, 4'hF, 32'h0000_0301, v);
    bus("div_a", 1'b0, 0, 4'hF, 32'h0, a);
    idle(38);
    bus("div_b", 1'b0, 0, 4'hF, 32'h0, b);
    chk("div_delta", {63'h0, ((b - a) >= 9) && ((b - a) <= 11)}, 64'h1);
    bus("ctrl_read", 1'b0, 4, 4'hF, 32'h0, v);
    bus("ctrl_off", 1'b1, 4, 4'hF, 32'h0000_0300, v);
    bus("frz_a", 1'b0, 0, 4'hF, 32'h0, v);
    idle(20);
    bus("frz_b", 1'b0, 0, 4'hF, 32'h0, v);

    // Interrupt rise at mtime==0x20 and fall on raising mtimecmp
    bus("ctrl_on", 1'b1, 4, 4'hF, 32'h0000_0001, v);
    bus("mt_hi0", 1'b1, 1, 4'hF, 32'h0, v);
    bus("mt_lo0", 1'b1, 0, 4'hF, 32'h0, v);
    bus("cmp_hi0", 1'b1, 3, 4'hF, 32'h0, v);
    bus("cmp_lo20", 1'b1, 2, 4'hF, 32'h0000_0020, v);
    idle(40);
    chk("irq_high", {63'h0, irq}, 64'h1);
    bus("cmp_lo_max", 1'b1, 2, 4'hF, 32'hFFFF_FFFF, v);
    chk("irq_fall", {63'h0, irq}, 64'h0);

    // Low-word carry into the high word
    bus("wrap_hi", 1'b1, 1, 4'hF, 32'h0, v);
    bus("wrap_lo", 1'b1, 0, 4'hF, 32'hFFFF_FFFE, v);
    idle(1);
    bus("wrap_rlo", 1'b0, 0, 4'hF, 32'h0, v);
    chk("wrap_lo_const", {32'h0, v}, 64'hFFFF_FFFF);
    bus("wrap_rhi", 1'b0, 1, 4'hF, 32'h0, v);
`ifdef WB_MTIMER_HI_LATCH_EN
    chk("wrap_hi_latched", {32'h0, v}, 64'h0);
`else
    chk("wrap_hi_live", {32'h0, v}, 64'h1);
`endif
    bus("wrap_rlo2", 1'b0, 0, 4'hF, 32'h0, v);

    // Four back-to-back requests with a partial-lane write
    bus("sel_pre", 1'b1, 2, 4'hF, 32'h1234_5678, v);
    bus("b2b_0", 1'b0, 0, 4'hF, 32'h0, v);
    bus("b2b_1", 1'b1, 2, 4'b0011, 32'hAABB_CCDD, v);
    bus("b2b_2", 1'b0, 2, 4'hF, 32'h0, v);
    chk("sel_merge", {32'h0, v}, 64'h1234_CCDD);
    bus("b2b_3", 1'b0, 3, 4'hF, 32'h0, v);

    // Aborted cycle: no ack, but the write lands
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 5'h0C; sel = 4'hF; dat_i = 32'h0000_0005;
    w = now() + 1;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(negedge clk);
    model_write(3, 4'hF, 32'h0000_0005, w);
    chk("abort_ack", {63'h0, ack}, 64'h0);
    chk("abort_dat", {32'h0, dat_o}, 64'h0);
    bus("abort_rb", 1'b0, 3, 4'hF, 32'h0, v);
    chk("abort_rb_const", {32'h0, v}, 64'h5);

    // Reset right after accepting a read, with the interrupt asserted
    bus("pre_cmp_hi", 1'b1, 3, 4'hF, 32'h0, v);
    bus("pre_cmp_lo", 1'b1, 2, 4'hF, 32'h0, v);
    chk("pre_irq", {63'h0, irq}, 64'h1);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 5'h04; sel = 4'hF;
    @(posedge clk);
    #1;
    chk("pre_rst_ack", {63'h0, ack}, 64'h1);
    rst = 1'b1;
    #1;
    chk("async_ack", {63'h0, ack}, 64'h0);
    chk("async_dat", {32'h0, dat_o}, 64'h0);
    chk("async_irq", {63'h0, irq}, 64'h0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("inrst_ack", {63'h0, ack}, 64'h0);
    rst = 1'b0;
    rel0 = edges;
    model_reset();
    bus("unmapped", 1'b0, 6, 4'hF, 32'h0, v);
    bus("post_rst_lo", 1'b0, 0, 4'hF, 32'h0, v);
    bus("post_rst_cmp", 1'b0, 2, 4'hF, 32'h0, v);

    // Randomized traffic against the model
    for (int i = 0; i < 80; i++) begin
      word = int'($urandom_range(0, 7));
      d = $urandom;
      if (word == 4) begin
        d[23:8] = 16'($urandom_range(0, 5));
        d[0]    = ($urandom_range(0, 3) != 0);
      end
      if (word == 3 && $urandom_range(0, 1) == 1) d = 32'h0;
      bus("rnd", 1'($urandom_range(0, 1)), word, 4'($urandom_range(0, 15)), d, v);
      idle(int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
